// File: rtl/wb_stage.sv
// Write-back stage: holds the retiring instruction, formats load data, and
// freezes the pipeline while a load waits for data memory.
module wb_stage #(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4,
  parameter int RA_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_mem,
  input  logic            flush_wb,
  input  logic [XLEN-1:0] sext_mem,
  input  logic [XLEN-1:0] alu_c_mem,
  input  logic [XLEN-1:0] pc_mem,
  input  logic [1:0]      wd_sel_mem,
  input  logic            rf_we_mem,
  input  logic [RA_W-1:0] wr_mem,
  input  logic [2:0]      ld_type_mem,
  input  logic            dram_rvalid,
  input  logic [XLEN-1:0] dram_rdata,
  output logic [XLEN-1:0] wD,
  output logic            rf_we,
  output logic [RA_W-1:0] wR,
  output logic            wb_valid,
  output logic            load_stall,
  output logic [XLEN-1:0] instret,
  output logic [31:0]     stall_cnt
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] sext_q, sext_d;
  logic [XLEN-1:0] alu_c_q, alu_c_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      wd_sel_q, wd_sel_d;
  logic            rf_we_q, rf_we_d;
  logic [RA_W-1:0] wr_q, wr_d;
  logic [2:0]      ld_type_q, ld_type_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  assign load_stall = (state_q == WAIT) & ~dram_rvalid;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    sext_d      = sext_q;
    alu_c_d     = alu_c_q;
    pc_d        = pc_q;
    wd_sel_d    = wd_sel_q;
    rf_we_d     = rf_we_q;
    wr_d        = wr_q;
    ld_type_d   = ld_type_q;
    instret_d   = instret_q;
    stall_cnt_d = stall_cnt_q;
    if (load_stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      if (valid_q) instret_d = instret_q + XLEN'(1);
      valid_d   = valid_mem & ~flush_wb;
      sext_d    = sext_mem;
      alu_c_d   = alu_c_mem;
      pc_d      = pc_mem;
      wd_sel_d  = wd_sel_mem;
      rf_we_d   = rf_we_mem;
      wr_d      = wr_mem;
      ld_type_d = ld_type_mem;
      // Leaving WAIT and capturing the next instruction share one edge, so a
      // back-to-back load re-enters WAIT immediately.
      state_d   = (valid_mem & ~flush_wb & (wd_sel_mem == 2'b11)) ? WAIT : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      sext_q      <= '0;
      alu_c_q     <= '0;
      pc_q        <= '0;
      wd_sel_q    <= '0;
      rf_we_q     <= 1'b0;
      wr_q        <= '0;
      ld_type_q   <= '0;
      instret_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      sext_q      <= sext_d;
      alu_c_q     <= alu_c_d;
      pc_q        <= pc_d;
      wd_sel_q    <= wd_sel_d;
      rf_we_q     <= rf_we_d;
      wr_q        <= wr_d;
      ld_type_q   <= ld_type_d;
      instret_q   <= instret_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    ld_byte = dram_rdata[{alu_c_q[1:0], 3'b000} +: 8];
    ld_half = dram_rdata[{alu_c_q[1], 4'b0000} +: 16];
    case (ld_type_q)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = dram_rdata;
    endcase
  end

  always_comb begin
    case (wd_sel_q)
      2'b00:   wD = sext_q;
      2'b01:   wD = alu_c_q;
      2'b10:   wD = pc_q + XLEN'(PC_INC);
      default: wD = ld_data;
    endcase
  end

  assign rf_we     = valid_q & rf_we_q & ~load_stall & (wr_q != '0);
  assign wR        = wr_q;
  assign wb_valid  = valid_q;
  assign instret   = instret_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: an instruction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_mem = 1'b0, flush_wb = 1'b0;
  logic [31:0] sext_mem = '0, alu_c_mem = '0, pc_mem = '0;
  logic [1:0]  wd_sel_mem = '0;
  logic        rf_we_mem = 1'b0;
  logic [4:0]  wr_mem = '0;
  logic [2:0]  ld_type_mem = '0;
  logic        dram_rvalid = 1'b0;
  logic [31:0] dram_rdata = '0;
  logic [31:0] wD, instret, stall_cnt;
  logic        rf_we, wb_valid, load_stall;
  logic [4:0]  wR;

  int checks = 0;
  int failures = 0;

  wb_stage #(.XLEN(32), .PC_INC(4), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .valid_mem(valid_mem), .flush_wb(flush_wb),
    .sext_mem(sext_mem), .alu_c_mem(alu_c_mem), .pc_mem(pc_mem),
    .wd_sel_mem(wd_sel_mem), .rf_we_mem(rf_we_mem), .wr_mem(wr_mem),
    .ld_type_mem(ld_type_mem), .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
    .wD(wD), .rf_we(rf_we), .wR(wR), .wb_valid(wb_valid), .load_stall(load_stall),
    .instret(instret), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction sitting in WB and whether it still awaits load data.
  logic        m_valid = 0, m_we = 0, m_busy = 0;
  logic [31:0] m_sext = 0, m_alu = 0, m_pc = 0, m_instret = 0, m_stall = 0;
  logic [1:0]  m_sel = 0;
  logic [4:0]  m_wr = 0;
  logic [2:0]  m_ld = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_we = 0; m_busy = 0; m_sext = 0; m_alu = 0; m_pc = 0;
      m_sel = 0; m_wr = 0; m_ld = 0; m_instret = 0; m_stall = 0;
    end else if (m_busy && !dram_rvalid) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    end else begin
      if (m_valid) m_instret = m_instret + 1;
      m_valid = valid_mem && !flush_wb;
      m_sext = sext_mem; m_alu = alu_c_mem; m_pc = pc_mem; m_sel = wd_sel_mem;
      m_we = rf_we_mem; m_wr = wr_mem; m_ld = ld_type_mem;
      m_busy = m_valid && (wd_sel_mem == 2'd3);
    end
  end

  function automatic logic [31:0] load_value(input logic [2:0] t, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * (addr % 4))) & 32'hFF;
    h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
    case (t)
      3'd0:    return (b >= 128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  always @(negedge clk) begin
    logic        e_stall;
    logic [31:0] e_wd;
    e_stall = m_busy && !dram_rvalid;
    case (m_sel)
      2'd0:    e_wd = m_sext;
      2'd1:    e_wd = m_alu;
      2'd2:    e_wd = m_pc + 4;
      default: e_wd = load_value(m_ld, m_alu, dram_rdata);
    endcase
    chk("model_wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
    chk("model_load_stall", {31'd0, load_stall}, {31'd0, e_stall});
    chk("model_rf_we", {31'd0, rf_we}, {31'd0, m_valid && m_we && (m_wr != 0) && !e_stall});
    chk("model_wR", {27'd0, wR}, {27'd0, m_wr});
    if (m_valid) chk("model_wD", wD, e_wd);
    chk("model_instret", instret, m_instret);
    chk("model_stall_cnt", stall_cnt, m_stall);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [4:0] wr, input logic [2:0] ld);
    valid_mem = 1; flush_wb = 0; wd_sel_mem = sel; alu_c_mem = alu; pc_mem = pc;
    wr_mem = wr; ld_type_mem = ld; rf_we_mem = 1; sext_mem = 32'h0000_0777;
  endtask

  initial begin
    tick; tick;
    @(negedge clk);
    chk("rst_wD", wD, 32'h0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'h0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'h0);
    chk("rst_load_stall", {31'd0, load_stall}, 32'h0);
    rst = 0;

    // ALU result
    offer(2'b01, 32'h1234, 32'h100, 5'd5, 3'd0);
    tick; valid_mem = 0;
    @(negedge clk);
    chk("alu_wD", wD, 32'h1234);
    chk("alu_rf_we", {31'd0, rf_we}, 32'h1);
    chk("alu_wR", {27'd0, wR}, 32'd5);
    tick; @(negedge clk);
    chk("alu_instret", instret, 32'd1);

    // JAL link wraps
    offer(2'b10, 32'h0, 32'hFFFF_FFFC, 5'd1, 3'd0);
    tick; valid_mem = 0;
    @(negedge clk);
    chk("jal_wD", wD, 32'h0);
    chk("jal_rf_we", {31'd0, rf_we}, 32'h1);
    tick; @(negedge clk);
    chk("jal_instret", instret, 32'd2);

    // LB with two wait cycles, MEM garbage ignored while stalled
    offer(2'b11, 32'h0000_0103, 32'h200, 5'd7, 3'd0);
    dram_rvalid = 0;
    tick;
    offer(2'b01, 32'hBAD0_BAD0, 32'h0, 5'd9, 3'd0);
    @(negedge clk);
    chk("lb_stall1", {31'd0, load_stall}, 32'h1);
    chk("lb_rf_we_stalled", {31'd0, rf_we}, 32'h0);
    tick; @(negedge clk);
    chk("lb_stall2", {31'd0, load_stall}, 32'h1);
    tick;
    dram_rvalid = 1; dram_rdata = 32'h80FF_00AA;
    offer(2'b11, 32'h0000_0002, 32'h204, 5'd8, 3'd5);   // back-to-back LHU
    @(negedge clk);
    chk("lb_stall_done", {31'd0, load_stall}, 32'h0);
    chk("lb_wD", wD, 32'hFFFF_FF80);
    chk("lb_rf_we", {31'd0, rf_we}, 32'h1);
    chk("lb_stall_cnt", stall_cnt, 32'd2);
    tick;
    valid_mem = 0; dram_rdata = 32'h8001_FFFF;
    @(negedge clk);
    chk("lhu_wD", wD, 32'h0000_8001);
    chk("lhu_stall", {31'd0, load_stall}, 32'h0);
    chk("lhu_wR", {27'd0, wR}, 32'd8);
    tick; dram_rvalid = 0;
    @(negedge clk);
    chk("loads_instret", instret, 32'd4);

    // flush, then write to x0
    offer(2'b01, 32'h55, 32'h0, 5'd3, 3'd0);
    flush_wb = 1;
    tick;
    offer(2'b01, 32'h66, 32'h0, 5'd0, 3'd0);
    @(negedge clk);
    chk("flush_wb_valid", {31'd0, wb_valid}, 32'h0);
    chk("flush_rf_we", {31'd0, rf_we}, 32'h0);
    tick; valid_mem = 0;
    @(negedge clk);
    chk("x0_wb_valid", {31'd0, wb_valid}, 32'h1);
    chk("x0_rf_we", {31'd0, rf_we}, 32'h0);

    // flush arriving while a load waits does not kill it
    offer(2'b11, 32'h0, 32'h300, 5'd3, 3'd2);
    tick;
    flush_wb = 1;
    @(negedge clk);
    chk("wflush_stall", {31'd0, load_stall}, 32'h1);
    chk("wflush_valid", {31'd0, wb_valid}, 32'h1);
    tick;
    flush_wb = 0; valid_mem = 0; dram_rvalid = 1; dram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wflush_wD", wD, 32'hDEAD_BEEF);
    chk("wflush_rf_we", {31'd0, rf_we}, 32'h1);
    tick;

    // every load type and offset, same-cycle data, back-to-back
    dram_rvalid = 1;
    for (int t = 0; t < 8; t++) begin
      for (int off = 0; off < 4; off++) begin
        offer(2'b11, 32'h0000_1000 + off, 32'h0, 5'(t * 4 + off + 1), 3'(t));
        tick;
        dram_rdata = $urandom;
      end
    end
    valid_mem = 0;
    tick;
    dram_rvalid = 0;

    // reset in the middle of a wait
    offer(2'b11, 32'h1, 32'h400, 5'd4, 3'd0);
    tick; valid_mem = 0;
    tick;
    rst = 1;
    tick; rst = 0;
    @(negedge clk);
    chk("rstw_load_stall", {31'd0, load_stall}, 32'h0);
    chk("rstw_instret", instret, 32'h0);
    chk("rstw_stall_cnt", stall_cnt, 32'h0);
    chk("rstw_wb_valid", {31'd0, wb_valid}, 32'h0);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
